jtag_master: RTL and testbench

//  Host-side JTAG driver: the initiator that drives the TAP pins of the jtag_tap/jtag_test_interface target.

---
 rtl/jtag_master.sv | 168 ++++++++++++++++
 tb/tb_jtag_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master.sv
// Host-side JTAG initiator: one IR/DR/reset scan per command, TCK = clk/(2*TCK_HALF).
// Latency: rsp_valid N*2*TCK_HALF clk after accept (N = TCK periods); a new command is taken only when cmd_ready (IDLE).
module jtag_master #(
    parameter int TCK_HALF = 5,
    parameter int MAX_LEN  = 32,
    parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               trst_o
);

    localparam int PER_W = $clog2(MAX_LEN + 7);
    localparam int CNT_W = $clog2(2 * TCK_HALF);
    localparam logic [CNT_W-1:0] C_RISE = CNT_W'(TCK_HALF - 1);
    localparam logic [CNT_W-1:0] C_END  = CNT_W'(2 * TCK_HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Returns {trst, tms, tdi} for TMS-list entry p of the given operation.
    function automatic logic [2:0] f_entry(input logic is_rst, input logic is_ir,
                                           input logic [PER_W-1:0] len,
                                           input logic [MAX_LEN-1:0] data,
                                           input logic [PER_W-1:0] p);
        logic [PER_W-1:0]   s;
        logic [MAX_LEN-1:0] sh;
        logic [2:0]         r;
        s  = is_ir ? PER_W'(4) : PER_W'(3);
        sh = data >> (p - s);
        r  = 3'b000;
        if (is_rst) begin
            if (p < PER_W'(5)) r = 3'b110;
        end else if (p < s) begin
            r[1] = (p == '0) || (is_ir && (p == PER_W'(1)));
        end else if (p < s + len) begin
            r[1] = (p == s + len - PER_W'(1));
            r[0] = sh[0];
        end else begin
            r[1] = (p == s + len);
        end
        return r;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_is_rst, r_is_ir;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_data;
    logic [PER_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_tck, r_tms, r_tdi, r_trst;
    logic               r_rsp_vld;
    logic [MAX_LEN-1:0] r_rsp;

    logic               w_accept;
    logic [LEN_W-1:0]   w_len_eff;
    logic               w_in_rst, w_in_ir;
    logic [PER_W-1:0]   w_shift_start, w_len_p;
    logic               w_shift, w_last, w_period_end;

    assign w_len_eff = (cmd_len == '0)               ? LEN_W'(1) :
                       (cmd_len > LEN_W'(MAX_LEN))   ? LEN_W'(MAX_LEN) : cmd_len;
    assign w_in_rst  = cmd_op[1];
    assign w_in_ir   = (cmd_op == 2'b01);

    assign w_shift_start = r_is_ir ? PER_W'(4) : PER_W'(3);
    assign w_len_p       = PER_W'(r_len);
    assign w_shift       = !r_is_rst && (r_period >= w_shift_start) &&
                           (r_period < w_shift_start + w_len_p);
    assign w_last        = r_is_rst ? (r_period == PER_W'(5))
                                    : (r_period == w_shift_start + w_len_p + PER_W'(1));
    assign w_period_end  = (r_cnt == C_END);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN:   if (w_period_end && w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_rst  <= 1'b0;
            r_is_ir   <= 1'b0;
            r_len     <= '0;
            r_data    <= '0;
            r_period  <= '0;
            r_cnt     <= '0;
            r_tck     <= 1'b0;
            r_tms     <= 1'b0;
            r_tdi     <= 1'b0;
            r_trst    <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_rsp     <= '0;
        end else begin
            r_rsp_vld <= 1'b0;
            if (w_accept) begin
                r_is_rst <= w_in_rst;
                r_is_ir  <= w_in_ir;
                r_len    <= w_len_eff;
                r_data   <= cmd_data;
                r_period <= '0;
                r_cnt    <= '0;
                r_tck    <= 1'b0;
                r_rsp    <= '0;
                {r_trst, r_tms, r_tdi} <= f_entry(w_in_rst, w_in_ir, PER_W'(w_len_eff),
                                                  cmd_data, '0);
            end else if (r_state == S_RUN) begin
                // TDO is captured on the same clk that raises TCK.
                if (r_cnt == C_RISE) begin
                    r_tck <= 1'b1;
                    if (w_shift)
                        r_rsp <= r_rsp | (MAX_LEN'(tdo) << (r_period - w_shift_start));
                end
                if (w_period_end) begin
                    r_cnt <= '0;
                    r_tck <= 1'b0;
                    if (w_last) begin
                        {r_trst, r_tms, r_tdi} <= 3'b000;
                        r_rsp_vld <= 1'b1;
                    end else begin
                        r_period <= r_period + PER_W'(1);
                        {r_trst, r_tms, r_tdi} <= f_entry(r_is_rst, r_is_ir, w_len_p, r_data,
                                                          r_period + PER_W'(1));
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = r_rsp_vld;
    assign rsp_data  = r_rsp;
    assign tck       = r_tck;
    assign tms       = r_tms;
    assign tdi       = r_tdi;
    assign trst_o    = r_trst;

endmodule

// File: tb/tb_jtag_master.sv
// Directed + randomized bench for jtag_master; a list-based model predicts TMS/TDI at each TCK rise,
// trst duration, response timing and captured data (tdo loops back to tdi, optionally inverted).
module tb_jtag_master;

    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        tck, tms, tdi, tdo, trst_o;
    bit          tdo_inv = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit   mon_tms [0:4095];
    bit   mon_tdi [0:4095];
    int   n_rise = 0;
    int   n_trst = 0;
    int   n_rsp  = 0;
    logic prev_tck = 1'b0;
    logic [31:0] last_rsp;

    jtag_master #(.TCK_HALF(H), .MAX_LEN(32)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .trst_o(trst_o)
    );

    assign tdo = tdi ^ tdo_inv;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_tck <= tck;
        if (tck && !prev_tck) begin
            mon_tms[n_rise] <= tms;
            mon_tdi[n_rise] <= tdi;
            n_rise <= n_rise + 1;
        end
        if (trst_o)    n_trst <= n_trst + 1;
        if (rsp_valid) n_rsp  <= n_rsp + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected TMS/TDI sequence built directly from the per-op entry lists.
    task automatic model(input logic [1:0] op, input int len_raw, input logic [31:0] data,
                         input bit inv, output int n, output logic [63:0] etms,
                         output logic [63:0] etdi, output logic [31:0] ersp, output int etrst);
        bit q_tms[$];
        bit q_tdi[$];
        int len;
        logic [63:0] mask;
        len  = (len_raw == 0) ? 1 : (len_raw > 32) ? 32 : len_raw;
        mask = (64'd1 << len) - 64'd1;
        if (op[1]) begin
            q_tms = '{1, 1, 1, 1, 1, 0};
            q_tdi = '{0, 0, 0, 0, 0, 0};
            ersp  = 32'h0;
            etrst = 5 * 2 * H;
        end else begin
            q_tms.push_back(1); q_tdi.push_back(0);
            if (op == 2'b01) begin q_tms.push_back(1); q_tdi.push_back(0); end
            q_tms.push_back(0); q_tdi.push_back(0);
            q_tms.push_back(0); q_tdi.push_back(0);
            for (int i = 0; i < len; i++) begin
                q_tms.push_back(i == len - 1);
                q_tdi.push_back(data[i]);
            end
            q_tms.push_back(1); q_tdi.push_back(0);
            q_tms.push_back(0); q_tdi.push_back(0);
            ersp  = (data ^ {32{inv}}) & mask[31:0];
            etrst = 0;
        end
        n    = q_tms.size();
        etms = '0;
        etdi = '0;
        for (int j = 0; j < n; j++) begin
            etms[j] = q_tms[j];
            etdi[j] = q_tdi[j];
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input int len_raw, input logic [31:0] data,
                           input bit inv, input bit junk);
        int n, etrst, base, r0, t0, rises;
        logic [63:0] etms, etdi, otms, otdi;
        logic [31:0] ersp;
        bit got;
        model(op, len_raw, data, inv, n, etms, etdi, ersp, etrst);
        @(negedge clk);
        chk("ready_at_start", 64'(cmd_ready), 64'd1);
        chk("rsp_valid_low_at_start", 64'(rsp_valid), 64'd0);
        chk("tck_low_between", 64'(tck), 64'd0);
        tdo_inv   = inv;
        r0        = n_rise;
        t0        = n_trst;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = 6'(len_raw);
        cmd_data  = data;
        base      = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = 6'($urandom);
        cmd_data  = $urandom;
        chk("busy_after_accept", 64'(busy), 64'd1);
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            if (rsp_valid) begin
                got       = 1'b1;
                cmd_valid = 1'b0;
            end else begin
                cmd_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        chk("rsp_seen", 64'(got), 64'd1);
        chk("rsp_cycle", 64'(cyc - base), 64'(n * 2 * H + 1));
        chk("rsp_data", 64'(rsp_data), 64'(ersp));
        rises = n_rise - r0;
        otms  = '0;
        otdi  = '0;
        for (int j = 0; j < rises && j < 64; j++) begin
            otms[j] = mon_tms[r0 + j];
            otdi[j] = mon_tdi[r0 + j];
        end
        chk("tck_rises", 64'(rises), 64'(n));
        chk("tms_at_rises", otms, etms);
        chk("tdi_at_rises", otdi, etdi);
        chk("trst_clks", 64'(n_trst - t0), 64'(etrst));
        last_rsp = ersp;
    endtask

    initial begin
        int base, r0, rsp0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 6'd0;
        cmd_data  = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tck", 64'(tck), 64'd0);
        chk("reset_tms", 64'(tms), 64'd0);
        chk("reset_tdi", 64'(tdi), 64'd0);
        chk("reset_trst", 64'(trst_o), 64'd0);
        chk("reset_ready", 64'(cmd_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        r0 = n_rise;
        repeat (20) @(negedge clk);
        chk("idle_no_tck", 64'(n_rise - r0), 64'd0);

        run_cmd(2'b10, 0, $urandom, 1'b0, 1'b0);
        run_cmd(2'b00, 32, 32'hDEADBEEF, 1'b0, 1'b0);
        run_cmd(2'b01, 4, 32'h0000000A, 1'b0, 1'b0);
        run_cmd(2'b00, 0, $urandom, 1'b0, 1'b1);
        run_cmd(2'b00, 40, $urandom, 1'b0, 1'b1);
        run_cmd(2'b11, 9, $urandom, 1'b0, 1'b0);
        run_cmd(2'b00, 17, $urandom, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("rsp_data_hold", 64'(rsp_data), 64'(last_rsp));

        for (int t = 0; t < 10; t++) begin
            run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 45), $urandom,
                    1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Abort a 32-bit DR scan at clk 50.
        @(negedge clk);
        chk("abort_ready_at_start", 64'(cmd_ready), 64'd1);
        tdo_inv   = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_len   = 6'd32;
        cmd_data  = $urandom;
        base      = cyc;
        rsp0      = n_rsp;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (49) @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        chk("abort_at_clk50", 64'(cyc - base), 64'd50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tck", 64'(tck), 64'd0);
        chk("abort_tms", 64'(tms), 64'd0);
        chk("abort_tdi", 64'(tdi), 64'd0);
        chk("abort_trst", 64'(trst_o), 64'd0);
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_rsp_data", 64'(rsp_data), 64'd0);
        repeat (200) @(negedge clk);
        chk("abort_no_rsp", 64'(n_rsp - rsp0), 64'd0);

        run_cmd(2'b10, 0, 32'h0, 1'b0, 1'b0);
        run_cmd(2'b01, 4, 32'h00000005, 1'b0, 1'b0);
        run_cmd(2'b00, 32, $urandom, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
